// File: rtl/carregador_elevador.sv
// -----------------------------------------------------------------------------
// carregador_elevador
//
// Holds objects waiting at each floor and, when the elevator door opens,
// loads the waiting objects of the current floor into the elevator content RAM.
//
// Storage is four independent 4-entry FIFOs, one per origin floor. Each entry
// holds {tipo, destino}. A loading FSM pops the latched floor's queue one
// object at a time, writing each into the RAM. It stops when the queue is
// empty or the RAM reports 8 occupied slots.
//
// Ports
//    clk                 rising-edge clock
//    clear               synchronous active-high reset
//    novo_objeto         push request (one object per cycle)
//    in_andar_origem     floor where the pushed object waits
//    in_tipo_objeto      pushed object type
//    in_destino_objeto   pushed object destination floor
//    iniciar_carga       one-cycle pulse: door open, loading may start
//    andar_atual         current elevator floor
//    qtd_ocupada         occupied RAM slots (0..8), valid one cycle after a write
//    weT                 RAM write strobe
//    out_tipo_objeto     type being written (0 when weT=0)
//    out_destino_objeto  destination being written (0 when weT=0)
//    tem_objeto_andar    bit n = floor-n queue non-empty (registered)
//    fila_cheia          bit n = floor-n queue full (registered)
//    carregando          high while the FSM is not idle
//    fim_carga           one-cycle pulse when loading finishes
//    erro_push           one-cycle pulse after a rejected push
// -----------------------------------------------------------------------------
module carregador_elevador (
   input  logic       clk,
   input  logic       clear,
   input  logic       novo_objeto,
   input  logic [1:0] in_andar_origem,
   input  logic [1:0] in_tipo_objeto,
   input  logic [1:0] in_destino_objeto,
   input  logic       iniciar_carga,
   input  logic [1:0] andar_atual,
   input  logic [3:0] qtd_ocupada,
   output logic       weT,
   output logic [1:0] out_tipo_objeto,
   output logic [1:0] out_destino_objeto,
   output logic [3:0] tem_objeto_andar,
   output logic [3:0] fila_cheia,
   output logic       carregando,
   output logic       fim_carga,
   output logic       erro_push
);

   typedef enum logic [2:0] {
      OCIOSO,
      CARGA,
      ESCREVE,
      ESPERA,
      FIM
   } estado_t;

   estado_t    r_estado;
   logic [1:0] r_andar;

   logic [1:0] r_memTipo    [0:3][0:3];
   logic [1:0] r_memDestino [0:3][0:3];
   logic [1:0] r_wrPtr      [0:3];
   logic [1:0] r_rdPtr      [0:3];
   logic [2:0] r_count      [0:3];

   logic       r_weT;
   logic [1:0] r_outTipo;
   logic [1:0] r_outDestino;
   logic [3:0] r_tem;
   logic [3:0] r_cheia;
   logic       r_carregando;
   logic       r_fim;
   logic       r_erro;

   logic [3:0] w_push;
   logic [3:0] w_pop;
   logic       w_aceita;
   logic       w_rejeita;
   logic [2:0] w_nextCount [0:3];

   // Push/pop decision. The only pop source is the FSM in ESCREVE, on the
   // latched floor. A full queue still accepts a push when it is being popped
   // in the same cycle, because the freed slot is exactly the one written.
   always_comb begin
      w_push    = '0;
      w_pop     = '0;
      w_aceita  = 1'b0;
      w_rejeita = 1'b0;
      w_pop[r_andar] = (r_estado == ESCREVE);
      if (novo_objeto) begin
         if ((in_destino_objeto != in_andar_origem) &&
             ((r_count[in_andar_origem] != 3'd4) || w_pop[in_andar_origem])) begin
            w_push[in_andar_origem] = 1'b1;
            w_aceita                = 1'b1;
         end else begin
            w_rejeita = 1'b1;
         end
      end
   end

   // Count after this cycle's push/pop. It feeds both the count registers and
   // the status flags, so the flags track the counts with one cycle of latency.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_nextCount[i] = r_count[i];
         case ({w_push[i], w_pop[i]})
            2'b10:   w_nextCount[i] = r_count[i] + 3'd1;
            2'b01:   w_nextCount[i] = r_count[i] - 3'd1;
            default: w_nextCount[i] = r_count[i];
         endcase
      end
   end

   // FIFO payload storage. It has no reset: a cleared queue has zero count,
   // so stale entries are never read.
   always_ff @(posedge clk) begin
      if (!clear && w_aceita) begin
         r_memTipo[in_andar_origem][r_wrPtr[in_andar_origem]]    <= in_tipo_objeto;
         r_memDestino[in_andar_origem][r_wrPtr[in_andar_origem]] <= in_destino_objeto;
      end
   end

   // FIFO pointers, counts, status flags and the push-error pulse. The 2-bit
   // pointers wrap from 3 to 0 naturally.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < 4; i++) begin
            r_wrPtr[i] <= '0;
            r_rdPtr[i] <= '0;
            r_count[i] <= '0;
         end
         r_tem   <= '0;
         r_cheia <= '0;
         r_erro  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_push[i]) r_wrPtr[i] <= r_wrPtr[i] + 2'd1;
            if (w_pop[i])  r_rdPtr[i] <= r_rdPtr[i] + 2'd1;
            r_count[i] <= w_nextCount[i];
            r_tem[i]   <= (w_nextCount[i] != 3'd0);
            r_cheia[i] <= (w_nextCount[i] == 3'd4);
         end
         r_erro <= w_rejeita;
      end
   end

   // Loading FSM. Outputs are registered on the transition into the state that
   // owns them, so weT and the write data are high exactly during ESCREVE.
   // The head is captured on the CARGA->ESCREVE edge. It cannot change before
   // the pop, because pushes only ever touch the tail. ESPERA gives the RAM
   // one cycle to update qtd_ocupada before the next CARGA check.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_estado     <= OCIOSO;
         r_andar      <= '0;
         r_weT        <= 1'b0;
         r_outTipo    <= '0;
         r_outDestino <= '0;
         r_fim        <= 1'b0;
         r_carregando <= 1'b0;
      end else begin
         r_weT        <= 1'b0;
         r_outTipo    <= '0;
         r_outDestino <= '0;
         r_fim        <= 1'b0;
         case (r_estado)
            OCIOSO: begin
               if (iniciar_carga) begin
                  r_andar      <= andar_atual;
                  r_estado     <= CARGA;
                  r_carregando <= 1'b1;
               end
            end
            CARGA: begin
               if ((r_count[r_andar] != 3'd0) && (qtd_ocupada < 4'd8)) begin
                  r_estado     <= ESCREVE;
                  r_weT        <= 1'b1;
                  r_outTipo    <= r_memTipo[r_andar][r_rdPtr[r_andar]];
                  r_outDestino <= r_memDestino[r_andar][r_rdPtr[r_andar]];
               end else begin
                  r_estado <= FIM;
                  r_fim    <= 1'b1;
               end
            end
            ESCREVE: r_estado <= ESPERA;
            ESPERA:  r_estado <= CARGA;
            FIM: begin
               r_estado     <= OCIOSO;
               r_carregando <= 1'b0;
            end
            default: begin
               r_estado     <= OCIOSO;
               r_carregando <= 1'b0;
            end
         endcase
      end
   end

   assign weT                = r_weT;
   assign out_tipo_objeto    = r_outTipo;
   assign out_destino_objeto = r_outDestino;
   assign tem_objeto_andar   = r_tem;
   assign fila_cheia         = r_cheia;
   assign carregando         = r_carregando;
   assign fim_carga          = r_fim;
   assign erro_push          = r_erro;

endmodule

// File: tb/tb_carregador_elevador.sv
// -----------------------------------------------------------------------------
// tb_carregador_elevador
//
// Directed bench for carregador_elevador. A small RAM model counts write
// strobes to produce qtd_ocupada and logs every written {tipo, destino} pair.
// Expected values are hand-derived from the object sequences pushed below.
// -----------------------------------------------------------------------------
module tb_carregador_elevador;

   logic       clk = 1'b0;
   logic       clear;
   logic       novo_objeto;
   logic [1:0] in_andar_origem;
   logic [1:0] in_tipo_objeto;
   logic [1:0] in_destino_objeto;
   logic       iniciar_carga;
   logic [1:0] andar_atual;
   logic [3:0] qtd_ocupada;
   logic       weT;
   logic [1:0] out_tipo_objeto;
   logic [1:0] out_destino_objeto;
   logic [3:0] tem_objeto_andar;
   logic [3:0] fila_cheia;
   logic       carregando;
   logic       fim_carga;
   logic       erro_push;

   int errorCount = 0;
   int checkCount = 0;
   int writeCount = 0;
   int writeMark  = 0;
   int fimCount   = 0;
   int fimBefore;
   int writesBefore;
   logic [3:0] qtdBase = 4'd0;
   logic [1:0] logTipo    [0:31];
   logic [1:0] logDestino [0:31];
   bit monitorOn = 1'b0;

   carregador_elevador dut (
      .clk                (clk),
      .clear              (clear),
      .novo_objeto        (novo_objeto),
      .in_andar_origem    (in_andar_origem),
      .in_tipo_objeto     (in_tipo_objeto),
      .in_destino_objeto  (in_destino_objeto),
      .iniciar_carga      (iniciar_carga),
      .andar_atual        (andar_atual),
      .qtd_ocupada        (qtd_ocupada),
      .weT                (weT),
      .out_tipo_objeto    (out_tipo_objeto),
      .out_destino_objeto (out_destino_objeto),
      .tem_objeto_andar   (tem_objeto_andar),
      .fila_cheia         (fila_cheia),
      .carregando         (carregando),
      .fim_carga          (fim_carga),
      .erro_push          (erro_push)
   );

   always #5 clk = ~clk;

   // RAM model: occupancy is the base level set by the scenario plus the
   // writes seen since the scenario's mark, visible the cycle after each write.
   assign qtd_ocupada = qtdBase + 4'(writeCount - writeMark);

   // Logs every written pair and counts done pulses.
   always @(posedge clk) begin
      if (weT === 1'b1) begin
         logTipo[writeCount % 32]    <= out_tipo_objeto;
         logDestino[writeCount % 32] <= out_destino_objeto;
         writeCount                  <= writeCount + 1;
      end
      if (fim_carga === 1'b1) fimCount <= fimCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // The write data must be zero whenever weT is low.
   always @(negedge clk) begin
      if (monitorOn && weT !== 1'b1)
         checkOutput("outZeroIdle", {4'd0, out_tipo_objeto, out_destino_objeto}, 8'h00);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic novo, input logic [1:0] origem,
                                input logic [1:0] tipo, input logic [1:0] destino);
      novo_objeto       = novo;
      in_andar_origem   = origem;
      in_tipo_objeto    = tipo;
      in_destino_objeto = destino;
      tick();
   endtask

   task automatic startLoad(input logic [1:0] andar, input logic [3:0] base);
      qtdBase       = base;
      writeMark     = writeCount;
      andar_atual   = andar;
      iniciar_carga = 1'b1;
      tick();
      iniciar_carga = 1'b0;
   endtask

   task automatic waitFim(input int maxCycles);
      int n = 0;
      while (fim_carga !== 1'b1 && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput("fimTimeout", {7'd0, fim_carga}, 8'd1);
   endtask

   initial begin
      clear             = 1'b1;
      novo_objeto       = 1'b0;
      in_andar_origem   = 2'd0;
      in_tipo_objeto    = 2'd0;
      in_destino_objeto = 2'd0;
      iniciar_carga     = 1'b0;
      andar_atual       = 2'd0;

      // Reset: two cycles of clear, then idle.
      tick();
      tick();
      clear = 1'b0;
      tick();
      monitorOn = 1'b1;
      checkOutput("rstWeT",        {7'd0, weT},        8'd0);
      checkOutput("rstOutTipo",    {6'd0, out_tipo_objeto},    8'd0);
      checkOutput("rstOutDestino", {6'd0, out_destino_objeto}, 8'd0);
      checkOutput("rstTem",        {4'd0, tem_objeto_andar},   8'd0);
      checkOutput("rstCheia",      {4'd0, fila_cheia},         8'd0);
      checkOutput("rstCarregando", {7'd0, carregando}, 8'd0);
      checkOutput("rstFim",        {7'd0, fim_carga},  8'd0);
      checkOutput("rstErro",       {7'd0, erro_push},  8'd0);

      // Load sequence at floor 1: (tipo 2, dest 3) then (tipo 1, dest 0).
      applyStimulus(1'b1, 2'd1, 2'd2, 2'd3);
      applyStimulus(1'b1, 2'd1, 2'd1, 2'd0);
      novo_objeto = 1'b0;
      checkOutput("loadTemBefore", {4'd0, tem_objeto_andar}, 8'b0000_0010);
      checkOutput("loadErro",      {7'd0, erro_push},        8'd0);
      startLoad(2'd1, 4'd0);
      checkOutput("loadCarregando", {7'd0, carregando}, 8'd1);
      waitFim(30);
      checkOutput("loadCarregFim", {7'd0, carregando}, 8'd1);
      checkOutput("loadWrites",    8'(writeCount - writeMark), 8'd2);
      checkOutput("loadW0", {4'd0, logTipo[writeMark % 32], logDestino[writeMark % 32]}, {4'd0, 2'd2, 2'd3});
      checkOutput("loadW1", {4'd0, logTipo[(writeMark + 1) % 32], logDestino[(writeMark + 1) % 32]}, {4'd0, 2'd1, 2'd0});
      checkOutput("loadTemAfter", {4'd0, tem_objeto_andar}, 8'd0);
      tick();
      checkOutput("loadFimPulse", {7'd0, fim_carga},  8'd0);
      checkOutput("loadIdle",     {7'd0, carregando}, 8'd0);

      // Capacity: floor 2 holds 3 objects, RAM at 7 -> one write only.
      // andar_atual changes mid-load and must be ignored.
      applyStimulus(1'b1, 2'd2, 2'd0, 2'd1);
      applyStimulus(1'b1, 2'd2, 2'd3, 2'd0);
      applyStimulus(1'b1, 2'd2, 2'd1, 2'd3);
      novo_objeto = 1'b0;
      startLoad(2'd2, 4'd7);
      andar_atual = 2'd1;
      waitFim(30);
      checkOutput("capWrites", 8'(writeCount - writeMark), 8'd1);
      checkOutput("capW0", {4'd0, logTipo[writeMark % 32], logDestino[writeMark % 32]}, {4'd0, 2'd0, 2'd1});
      checkOutput("capTem",   {4'd0, tem_objeto_andar}, 8'b0000_0100);
      checkOutput("capCheia", {4'd0, fila_cheia},       8'd0);
      tick();

      // Full queue 0 and the rejected fifth push.
      applyStimulus(1'b1, 2'd0, 2'd0, 2'd1);
      applyStimulus(1'b1, 2'd0, 2'd1, 2'd2);
      applyStimulus(1'b1, 2'd0, 2'd2, 2'd3);
      checkOutput("fullNotYet", {4'd0, fila_cheia}, 8'd0);
      applyStimulus(1'b1, 2'd0, 2'd3, 2'd1);
      checkOutput("fullCheia",  {4'd0, fila_cheia},       8'b0000_0001);
      checkOutput("fullTem",    {4'd0, tem_objeto_andar}, 8'b0000_0101);
      checkOutput("fullNoErro", {7'd0, erro_push},        8'd0);
      applyStimulus(1'b1, 2'd0, 2'd0, 2'd2);
      checkOutput("fullErro",   {7'd0, erro_push},  8'd1);
      checkOutput("fullCheia2", {4'd0, fila_cheia}, 8'b0000_0001);
      applyStimulus(1'b0, 2'd0, 2'd0, 2'd0);
      checkOutput("fullErroPulse", {7'd0, erro_push}, 8'd0);

      // Destination equals origin: rejected, queue 3 stays empty.
      applyStimulus(1'b1, 2'd3, 2'd1, 2'd3);
      checkOutput("sameErro", {7'd0, erro_push},        8'd1);
      checkOutput("sameTem",  {4'd0, tem_objeto_andar}, 8'b0000_0101);
      applyStimulus(1'b0, 2'd0, 2'd0, 2'd0);
      checkOutput("sameTem2", {4'd0, tem_objeto_andar}, 8'b0000_0101);

      // Simultaneous push/pop on full queue 1. Its pointers sit at 2, so the
      // four entries A..D wrap around slot 3 -> 0.
      applyStimulus(1'b1, 2'd1, 2'd0, 2'd2);
      applyStimulus(1'b1, 2'd1, 2'd1, 2'd3);
      applyStimulus(1'b1, 2'd1, 2'd2, 2'd0);
      applyStimulus(1'b1, 2'd1, 2'd3, 2'd2);
      novo_objeto = 1'b0;
      checkOutput("simCheia", {4'd0, fila_cheia}, 8'b0000_0011);
      startLoad(2'd1, 4'd0);
      tick();
      checkOutput("simEscreve", {7'd0, weT}, 8'd1);
      applyStimulus(1'b1, 2'd1, 2'd1, 2'd0);
      novo_objeto = 1'b0;
      checkOutput("simNoErro", {7'd0, erro_push},  8'd0);
      checkOutput("simCount4", {4'd0, fila_cheia}, 8'b0000_0011);
      waitFim(60);
      checkOutput("simWrites", 8'(writeCount - writeMark), 8'd5);
      checkOutput("simW0", {4'd0, logTipo[writeMark % 32],       logDestino[writeMark % 32]},       {4'd0, 2'd0, 2'd2});
      checkOutput("simW1", {4'd0, logTipo[(writeMark + 1) % 32], logDestino[(writeMark + 1) % 32]}, {4'd0, 2'd1, 2'd3});
      checkOutput("simW2", {4'd0, logTipo[(writeMark + 2) % 32], logDestino[(writeMark + 2) % 32]}, {4'd0, 2'd2, 2'd0});
      checkOutput("simW3", {4'd0, logTipo[(writeMark + 3) % 32], logDestino[(writeMark + 3) % 32]}, {4'd0, 2'd3, 2'd2});
      checkOutput("simW4", {4'd0, logTipo[(writeMark + 4) % 32], logDestino[(writeMark + 4) % 32]}, {4'd0, 2'd1, 2'd0});
      checkOutput("simTem", {4'd0, tem_objeto_andar}, 8'b0000_0101);
      tick();

      // Reset in the middle of a load of floor 2 (head is tipo 3, dest 0).
      startLoad(2'd2, 4'd0);
      tick();
      checkOutput("midWeT",  {7'd0, weT}, 8'd1);
      checkOutput("midHead", {4'd0, out_tipo_objeto, out_destino_objeto}, {4'd0, 2'd3, 2'd0});
      clear = 1'b1;
      tick();
      clear        = 1'b0;
      fimBefore    = fimCount;
      writesBefore = writeCount;
      checkOutput("midWeTOff",  {7'd0, weT},              8'd0);
      checkOutput("midTem",     {4'd0, tem_objeto_andar}, 8'd0);
      checkOutput("midCheia",   {4'd0, fila_cheia},       8'd0);
      checkOutput("midCarreg",  {7'd0, carregando},       8'd0);
      for (int i = 0; i < 6; i++) tick();
      checkOutput("midNoFim",    8'(fimCount - fimBefore),      8'd0);
      checkOutput("midNoWrites", 8'(writeCount - writesBefore), 8'd0);
      checkOutput("midIdle",     {7'd0, carregando},            8'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/carregador_elevador.md
CARREGADOR_ELEVADOR -- requirements
Module: carregador_elevador

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); clear input 1 (synchronous active-high reset).
REQ-002 The block SHALL have these data and request inputs:
- novo_objeto input 1: push request, one object per cycle.
- in_andar_origem input 2: floor where the object waits.
- in_tipo_objeto input 2: object type.
- in_destino_objeto input 2: destination floor.
REQ-003 The block SHALL have these control inputs:
- iniciar_carga input 1: one-cycle pulse; door open, loading may start.
- andar_atual input 2: current elevator floor.
- qtd_ocupada input 4: occupied slots in the elevator content RAM, 0..8, valid one cycle after each write.
REQ-004 The block SHALL have these RAM-side outputs:
- weT output 1: write strobe to the elevator content RAM.
- out_tipo_objeto output 2: type being written.
- out_destino_objeto output 2: destination being written.
REQ-005 The block SHALL have these status outputs:
- tem_objeto_andar output 4: bit n = floor-n queue non-empty.
- fila_cheia output 4: bit n = floor-n queue full.
- carregando output 1: high while not OCIOSO.
- fim_carga output 1: one-cycle done pulse.
- erro_push output 1: one-cycle pulse when a push is rejected.

Function
REQ-006 Storage SHALL be four independent FIFOs, one per origin floor, each 4 entries of {tipo, destino}, with 2-bit wrapping pointers and a 3-bit count.
REQ-007 A push SHALL be accepted in the cycle novo_objeto=1 when the target queue (in_andar_origem) is not full and in_destino_objeto differs from in_andar_origem.
REQ-008 A rejected push (queue full with no same-cycle pop, or destino==origem) SHALL leave all state unchanged and assert erro_push the next cycle for one cycle.
REQ-009 A push and a pop on the same queue in one cycle SHALL both occur, with count unchanged, including when that queue is full.
REQ-010 FSM states SHALL be OCIOSO, CARGA, ESCREVE, ESPERA and FIM.
REQ-011 In OCIOSO, iniciar_carga=1 SHALL latch andar_atual into an internal floor register and enter CARGA; later changes of andar_atual SHALL be ignored until OCIOSO.
REQ-012 In CARGA, if the latched floor's queue is non-empty and qtd_ocupada<8, the FSM SHALL enter ESCREVE; otherwise it SHALL enter FIM.
REQ-013 In ESCREVE, the block SHALL, for exactly one cycle:
- assert weT;
- drive out_tipo_objeto/out_destino_objeto from the queue head;
- pop that head;
- then enter ESPERA.
REQ-014 ESPERA SHALL last exactly one cycle with weT=0 and then return to CARGA, so consecutive writes are separated by at least 2 low cycles and qtd_ocupada is current at the next check.
REQ-015 FIM SHALL assert fim_carga for one cycle and then enter OCIOSO.
REQ-016 iniciar_carga outside OCIOSO SHALL be ignored.
REQ-017 out_tipo_objeto/out_destino_objeto SHALL be 0 whenever weT=0.
REQ-018 FIFO order per floor SHALL be preserved, and pointer wrap from 3 to 0 SHALL be seamless.
REQ-019 tem_objeto_andar and fila_cheia SHALL be registered and reflect counts after the current cycle's push/pop, with a one-cycle latency.

Reset
REQ-020 clear=1 at a rising edge SHALL:
- empty all queues, pointers and counts;
- force OCIOSO;
- drive weT, out_*, fim_carga, erro_push, carregando, tem_objeto_andar and fila_cheia to 0.
REQ-021 clear SHALL take priority over every other input, including mid-ESCREVE: a pending write is abandoned, and weT is 0 in the following cycle.

Verification
REQ-022 Reset: clear for 2 cycles, then idle -> all outputs 0, carregando=0.
REQ-023 Load sequence:
- Stimulus: push (origem 1, tipo 2, dest 3), then (1,1,0); qtd_ocupada=0; iniciar_carga with andar_atual=1.
- Response: weT pulses twice, carrying tipo/dest 2/3 then 1/0; then fim_carga; tem_objeto_andar=0000.
REQ-024 Capacity: queue 2 holds 3 objects, qtd_ocupada=7 rising to 8 after the first write -> exactly one weT, fim_carga, and tem_objeto_andar[2]=1 (2 objects remain).
REQ-025 Full and reject cases:
- 5 pushes to floor 0 -> fila_cheia[0]=1 after the 4th, and the 5th produces an erro_push pulse.
- Push with origem=dest=3 -> erro_push, and queue 3 is unchanged.
REQ-026 Simultaneous push/pop: full queue 1, loading at floor 1, push to floor 1 during ESCREVE -> push accepted, count stays 4, and the order is preserved across the pointer wrap.
REQ-027 Reset mid-load: clear asserted in the ESCREVE cycle -> weT=0 the next cycle, all queues empty, and no fim_carga.
